// File: rtl/cfg_chain_sequencer_if.sv
// cfg_chain_sequencer_if
// Bundles the control and status signals of the config-chain sequencer.
//   master : the controlling side; drives prgm_b / start and observes status
//   slave  : the sequencer itself
// Signals:
//   prgm_b    active-low program-mode enable
//   start     request to begin a programming sequence
//   blk_en    one-hot shift enable, bit i enables block i
//   blk_done  sticky per-block completion flags
//   bit_cnt   current bit index inside the active block
//   busy      high while shifting or in the inter-block gap
//   done      high once every block has been programmed
//   abort_err sticky abort flag (only when CFG_SEQ_ABORT_EN is defined)
interface cfg_chain_sequencer_if #(
   parameter int NUM_BLOCKS = 4,
   parameter int CNT_W      = 5
);
   logic                  prgm_b;
   logic                  start;
   logic [NUM_BLOCKS-1:0] blk_en;
   logic [NUM_BLOCKS-1:0] blk_done;
   logic [CNT_W-1:0]      bit_cnt;
   logic                  busy;
   logic                  done;
`ifdef CFG_SEQ_ABORT_EN
   logic                  abort_err;
`endif

   modport master (
      output prgm_b, start,
`ifdef CFG_SEQ_ABORT_EN
      input  abort_err,
`endif
      input  blk_en, blk_done, bit_cnt, busy, done
   );

   modport slave (
      input  prgm_b, start,
`ifdef CFG_SEQ_ABORT_EN
      output abort_err,
`endif
      output blk_en, blk_done, bit_cnt, busy, done
   );
endinterface

// File: rtl/cfg_chain_sequencer.sv
// cfg_chain_sequencer
// Walks NUM_BLOCKS daisy-chained config blocks in order, asserting each
// block's shift enable for CHAIN_LEN cycles with a one-cycle gap between
// blocks. All outputs come straight from flops.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    cfg_chain_sequencer_if.slave (prgm_b, start in; status out)
// Optional build macro:
//   CFG_SEQ_ABORT_EN  prgm_b=1 during SHIFT/GAP aborts to IDLE and sets
//                     the sticky abort_err flag.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start with prgm_b=0
// SHIFT | blk_en[idx] high, bit_cnt counting 0..CHAIN_LEN-1
// GAP   | one dead cycle between blocks, blk_en=0
// DONE  | all blocks programmed; leaves on prgm_b=1
module cfg_chain_sequencer #(
   parameter int CHAIN_LEN  = 26,
   parameter int NUM_BLOCKS = 4,
   parameter int CNT_W      = 5
) (
   input logic                   clk,
   input logic                   reset,
   cfg_chain_sequencer_if.slave  bus
);
   localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_GAP,
      S_DONE
   } state_t;

   state_t                state_q;
   logic [IDX_W-1:0]      idx_q;
   logic [CNT_W-1:0]      bit_cnt_q;
   logic [NUM_BLOCKS-1:0] blk_en_q;
   logic [NUM_BLOCKS-1:0] blk_done_q;
   logic                  busy_q;
   logic                  done_q;
`ifdef CFG_SEQ_ABORT_EN
   logic                  abort_err_q;
`endif

   logic                  last_bit;
   logic                  last_blk;
   logic [IDX_W-1:0]      idx_d;

   assign last_bit = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
   assign last_blk = (idx_q == IDX_W'(NUM_BLOCKS - 1));
   assign idx_d    = idx_q + IDX_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         bit_cnt_q   <= '0;
         blk_en_q    <= '0;
         blk_done_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef CFG_SEQ_ABORT_EN
         abort_err_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start && !bus.prgm_b) begin
                  state_q     <= S_SHIFT;
                  idx_q       <= '0;
                  bit_cnt_q   <= '0;
                  blk_done_q  <= '0;
                  blk_en_q    <= NUM_BLOCKS'(1);
                  busy_q      <= 1'b1;
`ifdef CFG_SEQ_ABORT_EN
                  abort_err_q <= 1'b0;
`endif
               end
            end
            S_SHIFT: begin
`ifdef CFG_SEQ_ABORT_EN
               if (bus.prgm_b) begin
                  state_q     <= S_IDLE;
                  blk_en_q    <= '0;
                  bit_cnt_q   <= '0;
                  busy_q      <= 1'b0;
                  abort_err_q <= 1'b1;
               end else
`endif
               if (last_bit) begin
                  blk_done_q <= blk_done_q | (NUM_BLOCKS'(1) << idx_q);
                  bit_cnt_q  <= '0;
                  blk_en_q   <= '0;
                  if (last_blk) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_GAP;
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_q + CNT_W'(1);
               end
            end
            S_GAP: begin
`ifdef CFG_SEQ_ABORT_EN
               if (bus.prgm_b) begin
                  state_q     <= S_IDLE;
                  blk_en_q    <= '0;
                  bit_cnt_q   <= '0;
                  busy_q      <= 1'b0;
                  abort_err_q <= 1'b1;
               end else
`endif
               begin
                  state_q  <= S_SHIFT;
                  idx_q    <= idx_d;
                  blk_en_q <= NUM_BLOCKS'(1) << idx_d;
               end
            end
            S_DONE: begin
               // blk_done is deliberately kept so software can read it later
               if (bus.prgm_b) begin
                  state_q <= S_IDLE;
                  done_q  <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.blk_en    = blk_en_q;
   assign bus.blk_done  = blk_done_q;
   assign bus.bit_cnt   = bit_cnt_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
`ifdef CFG_SEQ_ABORT_EN
   assign bus.abort_err = abort_err_q;
`endif
endmodule

// File: tb/tb_cfg_chain_sequencer.sv
module tb_cfg_chain_sequencer;
   localparam int L0 = 26;
   localparam int N0 = 4;
   localparam int L1 = 32;
   localparam int N1 = 1;

   logic clk;
   logic reset;
   int   n_total;
   int   n_bad;

   cfg_chain_sequencer_if #(.NUM_BLOCKS(N0), .CNT_W(5)) if0 ();
   cfg_chain_sequencer_if #(.NUM_BLOCKS(N1), .CNT_W(5)) if1 ();

   cfg_chain_sequencer #(.CHAIN_LEN(L0), .NUM_BLOCKS(N0), .CNT_W(5)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (if0.slave)
   );

   cfg_chain_sequencer #(.CHAIN_LEN(L1), .NUM_BLOCKS(N1), .CNT_W(5)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (if1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected outputs t edges after the edge that accepted start.
   // Each block occupies L shift cycles plus one gap cycle; the last gap is DONE.
   function automatic void model(input int t, input int l, input int n,
                                 output logic [31:0] en, output logic [31:0] cnt,
                                 output logic [31:0] bsy, output logic [31:0] dn,
                                 output logic [31:0] bd);
      int per;
      int b;
      int r;
      per = l + 1;
      if (t < n * per - 1) begin
         b   = t / per;
         r   = t % per;
         bsy = 1;
         dn  = 0;
         if (r < l) begin
            en  = 32'(1) << b;
            cnt = 32'(r);
            bd  = (32'(1) << b) - 1;
         end else begin
            en  = 0;
            cnt = 0;
            bd  = (32'(1) << (b + 1)) - 1;
         end
      end else begin
         en  = 0;
         cnt = 0;
         bsy = 0;
         dn  = 1;
         bd  = (32'(1) << n) - 1;
      end
   endfunction

   task automatic check0(input int t);
      logic [31:0] en, cnt, bsy, dn, bd;
      model(t, L0, N0, en, cnt, bsy, dn, bd);
      chk("blk_en",   32'(if0.blk_en),   en);
      chk("bit_cnt",  32'(if0.bit_cnt),  cnt);
      chk("busy",     32'(if0.busy),     bsy);
      chk("done",     32'(if0.done),     dn);
      chk("blk_done", 32'(if0.blk_done), bd);
   endtask

   task automatic check_idle0(input logic [31:0] bd, input string tag);
      chk({tag, "_blk_en"},   32'(if0.blk_en),   0);
      chk({tag, "_bit_cnt"},  32'(if0.bit_cnt),  0);
      chk({tag, "_busy"},     32'(if0.busy),     0);
      chk({tag, "_done"},     32'(if0.done),     0);
      chk({tag, "_blk_done"}, 32'(if0.blk_done), bd);
   endtask

   // Called #1 after a posedge. Starts a sequence and checks n_edges edges.
   // With wiggle set, prgm_b toggles randomly while SHIFT/GAP sample it.
   task automatic run0(input int n_edges, input bit wiggle);
      if0.start  = 1'b1;
      if0.prgm_b = 1'b0;
      for (int t = 0; t < n_edges; t++) begin
         @(posedge clk);
         #1;
         check0(t);
         if0.start  = 1'($urandom_range(0, 1));
         if0.prgm_b = (wiggle && t <= N0 * (L0 + 1) - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if0.start = 1'b0;
   endtask

   // Leave DONE, then confirm start is ignored while prgm_b=1.
   task automatic exit_done0();
      if0.prgm_b = 1'b1;
      if0.start  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check_idle0((32'(1) << N0) - 1, "exit");
      for (int k = 0; k < 3; k++) begin
         if0.start = 1'b1;
         @(posedge clk);
         #1;
         check_idle0((32'(1) << N0) - 1, "ign");
      end
      if0.start  = 1'b0;
      if0.prgm_b = 1'b0;
   endtask

   initial begin
      logic [31:0] en, cnt, bsy, dn, bd;
      n_total     = 0;
      n_bad       = 0;
      reset       = 1'b1;
      if0.start   = 1'b1;
      if0.prgm_b  = 1'b0;
      if1.start   = 1'b0;
      if1.prgm_b  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle0(0, "rst");
`ifdef CFG_SEQ_ABORT_EN
      chk("rst_abort_err", 32'(if0.abort_err), 0);
`endif
      if0.start  = 1'b0;
      if0.prgm_b = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      // start with prgm_b=1 is ignored
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         check_idle0(0, "prgm_hi");
         if0.start = 1'($urandom_range(0, 1));
      end
      if0.start  = 1'b0;
      if0.prgm_b = 1'b0;

      // full runs, random start noise and (without abort) random prgm_b noise
      for (int r = 0; r < 3; r++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
`ifdef CFG_SEQ_ABORT_EN
         run0(N0 * (L0 + 1) + 3, 1'b0);
`else
         run0(N0 * (L0 + 1) + 3, 1'b1);
`endif
         exit_done0();
      end

      // asynchronous reset mid-SHIFT
      run0(51, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      check_idle0(0, "async_rst");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_idle0(0, "post_rst");
      run0(N0 * (L0 + 1) + 2, 1'b0);
      exit_done0();

`ifdef CFG_SEQ_ABORT_EN
      // abort at block 2, bit 10
      run0(2 * (L0 + 1) + 10 + 1, 1'b0);
      chk("pre_abort_cnt", 32'(if0.bit_cnt), 10);
      if0.prgm_b = 1'b1;
      @(posedge clk);
      #1;
      check_idle0(32'h3, "abort");
      chk("abort_err_set", 32'(if0.abort_err), 1);
      @(posedge clk);
      #1;
      check_idle0(32'h3, "abort_hold");
      chk("abort_err_hold", 32'(if0.abort_err), 1);
      if0.prgm_b = 1'b0;
      if0.start  = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_clr", 32'(if0.abort_err), 0);
      check0(0);
      if0.start = 1'b0;
      for (int t = 1; t < N0 * (L0 + 1) + 1; t++) begin
         @(posedge clk);
         #1;
         check0(t);
      end
      exit_done0();
`endif

      // single 32-bit block: counter reaches 31 without wrapping
      if1.prgm_b = 1'b0;
      if1.start  = 1'b1;
      for (int t = 0; t < N1 * (L1 + 1) + 2; t++) begin
         @(posedge clk);
         #1;
         model(t, L1, N1, en, cnt, bsy, dn, bd);
         chk("d1_blk_en",   32'(if1.blk_en),   en);
         chk("d1_bit_cnt",  32'(if1.bit_cnt),  cnt);
         chk("d1_busy",     32'(if1.busy),     bsy);
         chk("d1_done",     32'(if1.done),     dn);
         chk("d1_blk_done", 32'(if1.blk_done), bd);
         if1.start = 1'($urandom_range(0, 1));
      end
      if1.prgm_b = 1'b1;
      if1.start  = 1'b0;
      @(posedge clk);
      #1;
      chk("d1_exit_done", 32'(if1.done), 0);
      chk("d1_exit_blk_done", 32'(if1.blk_done), 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/cfg_chain_sequencer.md
CFG_CHAIN_SEQUENCER -- requirements
Module: cfg_chain_sequencer

Interface
REQ-001 The block SHALL have parameter CHAIN_LEN, default 26, giving config bits per block, which is the shift-enable cycles per block.
REQ-002 The block SHALL have parameter NUM_BLOCKS, default 4, giving the number of daisy-chained config blocks sequenced in order.
REQ-003 The block SHALL have parameter CNT_W, default 5, giving the bit counter width; legal values satisfy 2^CNT_W >= CHAIN_LEN.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port prgm_b, input, 1 bit: active-low program mode; 0 means programming is allowed.
REQ-007 The block SHALL have port start, input, 1 bit: request to begin a programming sequence.
REQ-008 The block SHALL have port blk_en, output, NUM_BLOCKS bits: one-hot shift enable, where bit i enables block i.
REQ-009 The block SHALL have port blk_done, output, NUM_BLOCKS bits: sticky per-block completion flags.
REQ-010 The block SHALL have port bit_cnt, output, CNT_W bits: the current bit index within the active block.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in SHIFT or GAP.
REQ-012 The block SHALL have port done, output, 1 bit: high in DONE.
REQ-013 The block SHALL have port abort_err, output, 1 bit: sticky abort flag, present only with CFG_SEQ_ABORT_EN.

Function
REQ-014 All outputs SHALL be registered, with no combinational input-to-output paths.
REQ-015 The FSM SHALL have exactly four states: IDLE, SHIFT, GAP and DONE.
REQ-016 IDLE SHALL behave as follows:
- blk_en=0, busy=0, done=0.
- If start=1 and prgm_b=0 on an edge: go to SHIFT, set idx=0, set bit_cnt=0, and clear blk_done to 0.
- If start=1 and prgm_b=1: ignore start.
REQ-017 SHIFT SHALL behave as follows:
- blk_en = one-hot(idx), busy=1.
- bit_cnt increments by 1 each cycle.
REQ-018 When bit_cnt==CHAIN_LEN-1 in SHIFT, the next edge SHALL:
- set blk_done[idx]=1 and set bit_cnt=0;
- go to GAP if idx<NUM_BLOCKS-1, else go to DONE.
REQ-019 GAP SHALL last exactly one cycle with blk_en=0 and busy=1, then increment idx and return to SHIFT.
REQ-020 Timing SHALL be as follows:
- With start sampled at edge 0, blk_en[0] is high for edges 1..CHAIN_LEN.
- done rises at edge NUM_BLOCKS*CHAIN_LEN + NUM_BLOCKS; with defaults this is edge 108.
REQ-021 DONE SHALL hold done=1, blk_en=0, busy=0 and all blk_done bits at 1; on prgm_b=1 it goes to IDLE and clears done, while blk_done is retained.
REQ-022 start SHALL be ignored in SHIFT, GAP and DONE.
REQ-023 The bit counter SHALL never exceed CHAIN_LEN-1 and SHALL never wrap through 2^CNT_W.
REQ-024 idx SHALL never exceed NUM_BLOCKS-1.
REQ-025 blk_en SHALL never have more than one bit set.

Reset
REQ-026 While reset=1, the block SHALL be asynchronously forced to IDLE with idx=0, bit_cnt=0, blk_en=0, blk_done=0, busy=0, done=0 and abort_err=0.
REQ-027 Reset asserted mid-SHIFT SHALL drop blk_en to 0 immediately, without waiting for a clock edge.
REQ-028 After reset deasserts, the first state change SHALL occur no earlier than the next rising clk edge.

Configuration
REQ-029 The macro CFG_SEQ_ABORT_EN SHALL control the abort feature.
REQ-030 With CFG_SEQ_ABORT_EN defined:
- prgm_b=1 sampled in SHIFT or GAP forces the next state to IDLE, with blk_en=0 and bit_cnt=0.
- abort_err is set to 1 and blk_done bits already set are kept.
- abort_err is cleared only by reset or by an accepted start.
REQ-031 Without CFG_SEQ_ABORT_EN:
- the abort_err port is absent;
- prgm_b is ignored in SHIFT and GAP, so the sequence always runs to DONE.

Verification
REQ-032 Defaults, prgm_b=0, 1-cycle start pulse -> blk_en steps 0001,0000,0010,0000,0100,0000,1000, each non-zero value held 26 cycles; done=1 at edge 108; blk_done=1111.
REQ-033 Defaults, start=1 while prgm_b=1 -> FSM stays IDLE and all outputs stay 0.
REQ-034 With CFG_SEQ_ABORT_EN, prgm_b to 1 at block 2 when bit_cnt=10 -> next edge IDLE, blk_en=0000, blk_done=0011, abort_err=1; a later accepted start clears abort_err.
REQ-035 Without CFG_SEQ_ABORT_EN, the same prgm_b pulse -> sequence unaffected and done at edge 108.
REQ-036 reset pulsed at edge 50 -> blk_en=0 asynchronously; all outputs at reset values; a new start after release restarts at block 0.
REQ-037 CHAIN_LEN=32, CNT_W=5, NUM_BLOCKS=1 -> blk_en[0] high for 32 cycles, bit_cnt reaches 31 without wrap, done at edge 33.
